lcd_reg_dma: RTL and testbench
==============================

Name: lcd_reg_dma

Overview:
Parametrised successor of the LCD register bank. It holds the LCDC, STAT, SCY, SCX, LYC, BGP, OBP0, OBP1, DMA, WY and WX registers at a configurable base address on a split-data CPU bus. It adds two behaviours the earlier bank lacked:
- a STAT interrupt edge generator;
- a built-in OAM DMA sequencer that copies DMA_LEN bytes from {dma_reg, 8'h00} into OAM.

It sits between the CPU bus decoder, the PPU timing core, the memory read port and the OAM write port.

Parameters:
BASE_ADDR, 16'hFF40, address of LCDC; register offsets are 0x0–0xB (LCDC, STAT, SCY, SCX, LY, LYC, DMA, BGP, OBP0, OBP1, WY, WX).
DMA_LEN, 160, bytes per DMA transfer; legal range 1–256.
LCDC_RST, 8'h91, LCDC reset value.
BGP_RST, 8'hFC, BGP reset value.
OBP_RST, 8'hFF, reset value of OBP0 and OBP1.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
cpu_addr  in  16  CPU address
cpu_wdata  in  8  CPU write data
cpu_nwrite  in  1  active-low write strobe, sampled on clock edge
cpu_nread  in  1  active-low read enable
cpu_rdata  out  8  read data (combinational)
cpu_rsel  out  1  high when cpu_nread==0 and cpu_addr is in BASE_ADDR..BASE_ADDR+0xB
ly_coord  in  8  current LY from the PPU
ppu_mode  in  2  current PPU mode
lcdc  out  8  LCDC register
scy, scx, lyc, wy, wx  out  8 each  scroll, compare and window registers
bgp, obp0, obp1  out  8 each  palettes
stat_irq  out  1  one-cycle STAT interrupt request
dma_addr  out  16  DMA source address
dma_nread  out  1  active-low DMA read request
dma_rdata  in  8  memory data, valid one cycle after a dma_nread==0 cycle
oam_addr  out  8  OAM write index
oam_wdata  out  8  OAM write data
oam_we  out  1  OAM write strobe
dma_busy  out  1  high while a transfer is in progress

Behaviour:
- Reset (asynchronous): registers take these values.
  - lcdc=LCDC_RST, bgp=BGP_RST, obp0=obp1=OBP_RST.
  - STAT enables, scy, scx, lyc, wy, wx and dma_reg are 0.
  - FSM returns to IDLE, byte index=0, stat_prev=0.
  - Outputs: stat_irq=0, oam_we=0, dma_nread=1, dma_busy=0.
  - Reset mid-transfer aborts the transfer immediately; no further oam_we.
- Writes: on a rising edge with cpu_nwrite==0 and cpu_addr in range, the addressed register loads cpu_wdata.
  - STAT stores only cpu_wdata[6:3].
  - LY (offset 4) is read-only; writes to it are ignored.
  - Written values appear on the outputs the cycle after the write edge.
- Reads: cpu_rdata is combinational.
  - STAT reads {1'b1, en[3:0], lyc_eq, ppu_mode}, where lyc_eq = (ly_coord==lyc).
  - LY reads ly_coord; DMA reads dma_reg.
  - Out-of-range addresses or cpu_nread==1 give cpu_rdata=8'hFF and cpu_rsel=0.
- STAT interrupt:
  - line = (en[3]&lyc_eq) | (en[2]&mode==2) | (en[1]&mode==1) | (en[0]&mode==0).
  - stat_prev is registered from line every cycle.
  - stat_irq = line & ~stat_prev, so a continuously high line gives exactly one pulse. A mode change while the line stays high gives no new pulse.
- DMA FSM, states IDLE, RD, WR:
  - A write to offset 6 loads dma_reg, sets idx=0 and moves to RD on the same edge, from any state.
  - A write during RD or WR restarts the transfer: the in-flight byte is discarded and there is no oam_we for it.
  - RD: dma_nread=0, dma_addr={dma_reg, idx}. Next state is WR.
  - WR: oam_we=1, oam_addr=idx, oam_wdata=dma_rdata. If idx==DMA_LEN-1, go to IDLE with idx=0; otherwise idx+1 and go to RD.
  - dma_busy = (state != IDLE).
  - A transfer takes 2*DMA_LEN cycles from the write edge to the return to IDLE.
  - idx is 8 bits and never wraps past DMA_LEN-1.
  - A write to offset 6 in the same cycle as the final WR takes priority and restarts at idx 0.
  - In IDLE: oam_we=0, dma_nread=1, dma_addr=0.
- The CPU register path is independent of the DMA; the CPU can read and write other registers during a transfer.

Test Plan:
1. Assert reset asynchronously mid-cycle. Required: lcdc=0x91, bgp=0xFC, obp0=obp1=0xFF, STAT read 0x80|ppu_mode|lyc_eq<<2, dma_busy=0. A read of BASE+0x4 returns ly_coord.
2. Write 0x5A to each writable offset and read it back; STAT reads back with bits[6:3] only. Write 0x33 to BASE+0x4 and to BASE+0xC: no state changes. A read of BASE+0xC gives 0xFF, cpu_rsel=0.
3. STAT: set en[3]=1 and lyc=0x10, then sweep ly_coord 0x0F→0x10→0x10→0x11. Required: exactly one stat_irq pulse, in the cycle ly_coord first equals 0x10. With en[1]=1, hold mode=1 for 10 cycles: one pulse.
4. Write 0xC1 to BASE+0x6, with the memory model returning addr[7:0]^0xA5. Required: 160 oam_we pulses, oam_addr 0..159, oam_wdata=i^0xA5, dma_addr=0xC100+i. dma_busy is high for exactly 320 cycles.
5. Restart: write 0xC2 after 37 bytes have been written. Required: the next oam_we has oam_addr=0 and data from 0xC200; the transfer completes 320 cycles after the second write.
6. Reset asserted at byte 80 → oam_we drops that cycle and dma_busy=0. With DMA_LEN=1, one write, one oam_we, dma_busy high for 2 cycles.

Source files
------------

// File: rtl/lcd_reg_dma.sv
// LCD register bank with STAT interrupt edge detector and OAM DMA sequencer.
// Register reads are combinational; writes land on the clock edge; each DMA byte takes 2 cycles.
// No backpressure: memory answers one cycle after each read request, and OAM accepts every write.
module lcd_reg_dma #(
    parameter logic [15:0] BASE_ADDR = 16'hFF40,
    parameter int          DMA_LEN   = 160,
    parameter logic [7:0]  LCDC_RST  = 8'h91,
    parameter logic [7:0]  BGP_RST   = 8'hFC,
    parameter logic [7:0]  OBP_RST   = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_nwrite,
    input  logic        cpu_nread,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rsel,
    input  logic [7:0]  ly_coord,
    input  logic [1:0]  ppu_mode,
    output logic [7:0]  lcdc,
    output logic [7:0]  scy,
    output logic [7:0]  scx,
    output logic [7:0]  lyc,
    output logic [7:0]  wy,
    output logic [7:0]  wx,
    output logic [7:0]  bgp,
    output logic [7:0]  obp0,
    output logic [7:0]  obp1,
    output logic        stat_irq,
    output logic [15:0] dma_addr,
    output logic        dma_nread,
    input  logic [7:0]  dma_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_busy
);

    typedef enum logic [1:0] {IDLE, RD, WR} dma_state_t;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    logic [7:0] lcdc_q, lcdc_d, scy_q, scy_d, scx_q, scx_d, lyc_q, lyc_d;
    logic [7:0] dma_q, dma_d, bgp_q, bgp_d, obp0_q, obp0_d, obp1_q, obp1_d;
    logic [7:0] wy_q, wy_d, wx_q, wx_d;
    logic [3:0] en_q, en_d;
    logic       stat_prev_q, stat_prev_d;
    dma_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d;

    // Subtracting the base keeps the window check correct even if it sits near 16'hFFFF.
    logic [15:0] offset;
    logic        in_range, wr_hit, dma_start, lyc_eq, stat_line;
    logic [3:0]  reg_sel;

    assign offset    = cpu_addr - BASE_ADDR;
    assign in_range  = (offset < 16'd12);
    assign reg_sel   = offset[3:0];
    assign wr_hit    = ~cpu_nwrite & in_range;
    assign dma_start = wr_hit && (reg_sel == 4'd6);
    assign cpu_rsel  = ~cpu_nread & in_range;

    assign lyc_eq    = (ly_coord == lyc_q);
    assign stat_line = (en_q[3] & lyc_eq) | (en_q[2] & (ppu_mode == 2'd2)) |
                       (en_q[1] & (ppu_mode == 2'd1)) | (en_q[0] & (ppu_mode == 2'd0));
    // Rising edge of the combined condition only; masked while reset holds stat_prev low.
    assign stat_irq  = stat_line & ~stat_prev_q & ~reset;

    // CPU register writes; LY (offset 4) has no storage and ignores writes.
    always_comb begin
        lcdc_d = lcdc_q; scy_d = scy_q; scx_d = scx_q; lyc_d = lyc_q;
        dma_d  = dma_q;  bgp_d = bgp_q; obp0_d = obp0_q; obp1_d = obp1_q;
        wy_d   = wy_q;   wx_d  = wx_q;  en_d = en_q;
        stat_prev_d = stat_line;
        if (wr_hit) begin
            case (reg_sel)
                4'd0:    lcdc_d = cpu_wdata;
                4'd1:    en_d   = cpu_wdata[6:3];
                4'd2:    scy_d  = cpu_wdata;
                4'd3:    scx_d  = cpu_wdata;
                4'd5:    lyc_d  = cpu_wdata;
                4'd6:    dma_d  = cpu_wdata;
                4'd7:    bgp_d  = cpu_wdata;
                4'd8:    obp0_d = cpu_wdata;
                4'd9:    obp1_d = cpu_wdata;
                4'd10:   wy_d   = cpu_wdata;
                4'd11:   wx_d   = cpu_wdata;
                default: ;
            endcase
        end
    end

    // Combinational read mux; anything not selected floats high like an open bus.
    always_comb begin
        cpu_rdata = 8'hFF;
        if (cpu_rsel) begin
            case (reg_sel)
                4'd0:    cpu_rdata = lcdc_q;
                4'd1:    cpu_rdata = {1'b1, en_q, lyc_eq, ppu_mode};
                4'd2:    cpu_rdata = scy_q;
                4'd3:    cpu_rdata = scx_q;
                4'd4:    cpu_rdata = ly_coord;
                4'd5:    cpu_rdata = lyc_q;
                4'd6:    cpu_rdata = dma_q;
                4'd7:    cpu_rdata = bgp_q;
                4'd8:    cpu_rdata = obp0_q;
                4'd9:    cpu_rdata = obp1_q;
                4'd10:   cpu_rdata = wy_q;
                4'd11:   cpu_rdata = wx_q;
                default: cpu_rdata = 8'hFF;
            endcase
        end
    end

    // DMA sequencer: RD issues the memory read, WR commits the returned byte to OAM.
    // A new DMA write overrides everything, including the final WR, and kills the in-flight byte.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dma_nread = 1'b1;
        dma_addr  = 16'h0000;
        oam_we    = 1'b0;
        oam_wdata = 8'h00;
        case (state_q)
            RD: begin
                dma_nread = 1'b0;
                dma_addr  = {dma_q, idx_q};
                state_d   = WR;
            end
            WR: begin
                oam_we    = ~dma_start;
                oam_wdata = dma_rdata;
                if (idx_q == LAST_IDX) begin
                    idx_d   = 8'h00;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = RD;
                end
            end
            default: ;
        endcase
        if (dma_start) begin
            idx_d   = 8'h00;
            state_d = RD;
        end
    end

    assign oam_addr = idx_q;
    assign dma_busy = (state_q != IDLE);

    // State registers with asynchronous reset; reset also aborts any transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lcdc_q <= LCDC_RST; bgp_q <= BGP_RST; obp0_q <= OBP_RST; obp1_q <= OBP_RST;
            scy_q <= 8'h00; scx_q <= 8'h00; lyc_q <= 8'h00; dma_q <= 8'h00;
            wy_q <= 8'h00; wx_q <= 8'h00; en_q <= 4'h0;
            stat_prev_q <= 1'b0;
            state_q <= IDLE;
            idx_q <= 8'h00;
        end else begin
            lcdc_q <= lcdc_d; bgp_q <= bgp_d; obp0_q <= obp0_d; obp1_q <= obp1_d;
            scy_q <= scy_d; scx_q <= scx_d; lyc_q <= lyc_d; dma_q <= dma_d;
            wy_q <= wy_d; wx_q <= wx_d; en_q <= en_d;
            stat_prev_q <= stat_prev_d;
            state_q <= state_d;
            idx_q <= idx_d;
        end
    end

    assign lcdc = lcdc_q; assign scy = scy_q; assign scx = scx_q; assign lyc = lyc_q;
    assign wy = wy_q; assign wx = wx_q; assign bgp = bgp_q;
    assign obp0 = obp0_q; assign obp1 = obp1_q;

endmodule

// File: tb/tb_lcd_reg_dma.sv
// Directed bench for lcd_reg_dma: register bank, STAT edge generator and OAM DMA.
// Main instance uses DMA_LEN=160; a second instance with DMA_LEN=1 checks the minimal transfer.
// Memory models answer one cycle after each read request with addr[7:0]^0xA5.
module tb_lcd_reg_dma;

    localparam logic [15:0] BASE = 16'hFF40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_nwrite = 1'b1, cpu_nwrite1 = 1'b1;
    logic        cpu_nread = 1'b1;
    logic [7:0]  ly_coord = 8'h05;
    logic [1:0]  ppu_mode = 2'd2;

    logic [7:0]  cpu_rdata, lcdc, scy, scx, lyc, wy, wx, bgp, obp0, obp1;
    logic        cpu_rsel, stat_irq, dma_nread, oam_we, dma_busy;
    logic [15:0] dma_addr;
    logic [7:0]  oam_addr, oam_wdata, mem_dat;

    logic [7:0]  cpu_rdata1, lcdc1, scy1, scx1, lyc1, wy1, wx1, bgp1, obp01, obp11;
    logic        cpu_rsel1, stat_irq1, dma_nread1, oam_we1, dma_busy1;
    logic [15:0] dma_addr1;
    logic [7:0]  oam_addr1, oam_wdata1, mem_dat1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!dma_nread)  mem_dat  <= dma_addr[7:0] ^ 8'hA5;
        if (!dma_nread1) mem_dat1 <= dma_addr1[7:0] ^ 8'hA5;
    end

    lcd_reg_dma dut (
        .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_nwrite(cpu_nwrite), .cpu_nread(cpu_nread), .cpu_rdata(cpu_rdata),
        .cpu_rsel(cpu_rsel), .ly_coord(ly_coord), .ppu_mode(ppu_mode),
        .lcdc(lcdc), .scy(scy), .scx(scx), .lyc(lyc), .wy(wy), .wx(wx),
        .bgp(bgp), .obp0(obp0), .obp1(obp1), .stat_irq(stat_irq),
        .dma_addr(dma_addr), .dma_nread(dma_nread), .dma_rdata(mem_dat),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we), .dma_busy(dma_busy)
    );

    lcd_reg_dma #(.DMA_LEN(1)) dut1 (
        .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_nwrite(cpu_nwrite1), .cpu_nread(cpu_nread), .cpu_rdata(cpu_rdata1),
        .cpu_rsel(cpu_rsel1), .ly_coord(ly_coord), .ppu_mode(ppu_mode),
        .lcdc(lcdc1), .scy(scy1), .scx(scx1), .lyc(lyc1), .wy(wy1), .wx(wx1),
        .bgp(bgp1), .obp0(obp01), .obp1(obp11), .stat_irq(stat_irq1),
        .dma_addr(dma_addr1), .dma_nread(dma_nread1), .dma_rdata(mem_dat1),
        .oam_addr(oam_addr1), .oam_wdata(oam_wdata1), .oam_we(oam_we1), .dma_busy(dma_busy1)
    );

    // One CPU write cycle; returns 1 time unit after the write edge.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_nwrite = 1'b0;
        @(posedge clock); #1;
        cpu_nwrite = 1'b1;
    endtask

    // Follows a running transfer until dma_busy drops; counts busy cycles, OAM writes,
    // and beats whose address or data disagree with the expected byte sequence.
    task automatic watch_dma(input logic [7:0] src, output int busy, output int wes, output int bad);
        int rds;
        busy = 0; wes = 0; bad = 0; rds = 0;
        for (int c = 0; c < 400; c++) begin
            if (!dma_busy) break;
            busy++;
            if (!dma_nread) begin
                if (dma_addr !== {src, 8'(rds)}) bad++;
                rds++;
            end
            if (oam_we) begin
                if (oam_addr !== 8'(wes) || oam_wdata !== (8'(wes) ^ 8'hA5)) bad++;
                wes++;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        cpu_write(BASE + 16'd0, 8'h00);
        cpu_write(BASE + 16'd7, 8'h00);
        #3 reset = 1'b1;
        #1;
        total_cnt++;
        if (lcdc !== 8'h91) $display("FAIL reset_lcdc: got %h want 91", lcdc); else pass_cnt++;
        total_cnt++;
        if ({bgp, obp0, obp1} !== 24'hFCFFFF) $display("FAIL reset_pal: got %h want fcffff", {bgp, obp0, obp1}); else pass_cnt++;
        cpu_addr = BASE + 16'd1; cpu_nread = 1'b0; #1;
        total_cnt++;
        if (cpu_rdata !== 8'h82 || cpu_rsel !== 1'b1) $display("FAIL reset_stat: got %h rsel %b want 82 rsel 1", cpu_rdata, cpu_rsel); else pass_cnt++;
        cpu_addr = BASE + 16'd4; #1;
        total_cnt++;
        if (cpu_rdata !== 8'h05) $display("FAIL reset_ly: got %h want 05", cpu_rdata); else pass_cnt++;
        total_cnt++;
        if ({dma_busy, dma_nread, oam_we, stat_irq} !== 4'b0100) $display("FAIL reset_dma_outs: got %b want 0100", {dma_busy, dma_nread, oam_we, stat_irq}); else pass_cnt++;
        cpu_nread = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
    endtask

    task automatic test_regs;
        int offs[9] = '{0, 2, 3, 5, 7, 8, 9, 10, 11};
        ppu_mode = 2'd0;
        foreach (offs[i]) begin
            cpu_write(BASE + 16'(offs[i]), 8'h5A);
            cpu_addr = BASE + 16'(offs[i]); cpu_nread = 1'b0; #1;
            total_cnt++;
            if (cpu_rdata !== 8'h5A) $display("FAIL reg_rb_%0d: got %h want 5a", offs[i], cpu_rdata); else pass_cnt++;
            cpu_nread = 1'b1;
        end
        cpu_write(BASE + 16'd1, 8'h5A);
        cpu_addr = BASE + 16'd1; cpu_nread = 1'b0; #1;
        total_cnt++;
        if (cpu_rdata !== 8'hD8) $display("FAIL stat_rb: got %h want d8", cpu_rdata); else pass_cnt++;
        cpu_nread = 1'b1;
        total_cnt++;
        if ({lcdc, scy, scx, lyc, bgp, obp0, obp1, wy, wx} !== {9{8'h5A}})
            $display("FAIL reg_outs: got %h want all 5a", {lcdc, scy, scx, lyc, bgp, obp0, obp1, wy, wx}); else pass_cnt++;
        cpu_write(BASE + 16'd4, 8'h33);
        cpu_write(BASE + 16'd12, 8'h33);
        total_cnt++;
        if ({lcdc, scy, scx, lyc, bgp, obp0, obp1, wy, wx, dma_busy} !== {{9{8'h5A}}, 1'b0})
            $display("FAIL ignored_wr: got %h want all 5a, idle", {lcdc, scy, scx, lyc, bgp, obp0, obp1, wy, wx, dma_busy}); else pass_cnt++;
        cpu_addr = BASE + 16'd4; cpu_nread = 1'b0; #1;
        total_cnt++;
        if (cpu_rdata !== 8'h05) $display("FAIL ly_ro: got %h want 05", cpu_rdata); else pass_cnt++;
        cpu_addr = BASE + 16'd1; #1;
        total_cnt++;
        if (cpu_rdata !== 8'hD8) $display("FAIL stat_after_ignored: got %h want d8", cpu_rdata); else pass_cnt++;
        cpu_addr = BASE + 16'd12; #1;
        total_cnt++;
        if (cpu_rdata !== 8'hFF || cpu_rsel !== 1'b0) $display("FAIL out_of_range: got %h rsel %b want ff rsel 0", cpu_rdata, cpu_rsel); else pass_cnt++;
        cpu_addr = BASE; cpu_nread = 1'b1; #1;
        total_cnt++;
        if (cpu_rdata !== 8'hFF || cpu_rsel !== 1'b0) $display("FAIL nread_high: got %h rsel %b want ff rsel 0", cpu_rdata, cpu_rsel); else pass_cnt++;
    endtask

    task automatic test_stat;
        logic [7:0] lys[4] = '{8'h0F, 8'h10, 8'h10, 8'h11};
        int pulses, at;
        ppu_mode = 2'd3; ly_coord = 8'h0F;
        cpu_write(BASE + 16'd5, 8'h10);
        cpu_write(BASE + 16'd1, 8'h40);
        repeat (2) @(posedge clock);
        #1;
        pulses = 0; at = -1;
        for (int i = 0; i < 4; i++) begin
            ly_coord = lys[i]; #1;
            if (stat_irq) begin pulses++; at = i; end
            @(posedge clock); #1;
        end
        total_cnt++;
        if (pulses !== 1 || at !== 1) $display("FAIL stat_lyc: got %0d pulses at step %0d want 1 at 1", pulses, at); else pass_cnt++;
        cpu_write(BASE + 16'd1, 8'h10);
        @(posedge clock); #1;
        ppu_mode = 2'd1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            #1 if (stat_irq) pulses++;
            @(posedge clock); #1;
        end
        total_cnt++;
        if (pulses !== 1) $display("FAIL stat_mode1: got %0d pulses want 1", pulses); else pass_cnt++;
        cpu_write(BASE + 16'd1, 8'h30);
        ppu_mode = 2'd2;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            #1 if (stat_irq) pulses++;
            @(posedge clock); #1;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL stat_mode_change: got %0d pulses want 0", pulses); else pass_cnt++;
        cpu_write(BASE + 16'd1, 8'h00);
        ppu_mode = 2'd0;
    endtask

    task automatic test_dma;
        int busy, wes, bad;
        cpu_write(BASE + 16'd6, 8'hC1);
        watch_dma(8'hC1, busy, wes, bad);
        total_cnt++;
        if (busy !== 320) $display("FAIL dma_busy_len: got %0d want 320", busy); else pass_cnt++;
        total_cnt++;
        if (wes !== 160) $display("FAIL dma_we_count: got %0d want 160", wes); else pass_cnt++;
        total_cnt++;
        if (bad !== 0) $display("FAIL dma_beats: got %0d bad beats want 0", bad); else pass_cnt++;
        cpu_addr = BASE + 16'd6; cpu_nread = 1'b0; #1;
        total_cnt++;
        if (cpu_rdata !== 8'hC1) $display("FAIL dma_reg_rb: got %h want c1", cpu_rdata); else pass_cnt++;
        cpu_nread = 1'b1;
    endtask

    task automatic test_restart;
        int busy, wes, bad, seen;
        cpu_write(BASE + 16'd6, 8'hC1);
        seen = 0;
        for (int c = 0; c < 200 && seen < 37; c++) begin
            if (oam_we) seen++;
            if (seen < 37) begin @(posedge clock); #1; end
        end
        total_cnt++;
        if (seen !== 37) $display("FAIL restart_prefix: got %0d writes want 37", seen); else pass_cnt++;
        @(posedge clock); #1;
        cpu_write(BASE + 16'd6, 8'hC2);
        watch_dma(8'hC2, busy, wes, bad);
        total_cnt++;
        if (busy !== 320 || wes !== 160) $display("FAIL restart_len: got busy %0d we %0d want 320 160", busy, wes); else pass_cnt++;
        total_cnt++;
        if (bad !== 0) $display("FAIL restart_beats: got %0d bad beats want 0", bad); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int found, wes;
        cpu_write(BASE + 16'd6, 8'hC1);
        found = 0;
        for (int c = 0; c < 400; c++) begin
            if (oam_we && oam_addr == 8'd80) begin found = 1; break; end
            @(posedge clock); #1;
        end
        total_cnt++;
        if (found !== 1) $display("FAIL mid_reach_80: got %0d want 1", found); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({oam_we, dma_busy, dma_nread} !== 3'b001) $display("FAIL mid_reset_abort: got %b want 001", {oam_we, dma_busy, dma_nread}); else pass_cnt++;
        @(posedge clock); #1 reset = 1'b0;
        wes = 0;
        for (int c = 0; c < 6; c++) begin
            if (oam_we || dma_busy) wes++;
            @(posedge clock); #1;
        end
        total_cnt++;
        if (wes !== 0) $display("FAIL mid_after_reset: got %0d active cycles want 0", wes); else pass_cnt++;
    endtask

    task automatic test_len1;
        int busy, wes, bad;
        cpu_addr = BASE + 16'd6; cpu_wdata = 8'hC1; cpu_nwrite1 = 1'b0;
        @(posedge clock); #1;
        cpu_nwrite1 = 1'b1;
        busy = 0; wes = 0; bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (!dma_busy1) break;
            busy++;
            if (!dma_nread1 && dma_addr1 !== 16'hC100) bad++;
            if (oam_we1) begin
                wes++;
                if (oam_addr1 !== 8'h00 || oam_wdata1 !== 8'hA5) bad++;
            end
            @(posedge clock); #1;
        end
        total_cnt++;
        if (busy !== 2 || wes !== 1) $display("FAIL len1_timing: got busy %0d we %0d want 2 1", busy, wes); else pass_cnt++;
        total_cnt++;
        if (bad !== 0) $display("FAIL len1_beat: got %0d bad beats want 0", bad); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_regs;
        test_stat;
        test_dma;
        test_restart;
        test_reset_mid;
        test_len1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
